// File: rtl/branch_ctrl.sv
// branch_ctrl
//   Branch-control unit sitting between the decoder/ALU and the program
//   counter. It holds three branch-target registers (BR0..BR2), each
//   loaded atomically by a low write followed by a high write. It also
//   keeps the ALU zero flag from a compare until the branch that uses it.
//   Jump outputs are combinational from the current inputs and registers,
//   so a branch resolves in the same cycle it is decoded.
//
// Ports
//   Clk       clock, all state changes on the rising edge
//   Reset     synchronous active-high reset, clears all state
//   BrSel     branch register select (0..2 valid, 3 illegal)
//   WrLo      stage WrData[7:0] as the low part of target BrSel
//   WrHi      write WrData[L-9:0] as the high part and commit the target
//   WrData    narrow write data
//   ZeroIn    ALU zero result
//   FlagWe    compare instruction, latch ZeroIn into the flag
//   JeReq     decoder has a je instruction
//   JneReq    decoder has a jne instruction
//   JmpEq     je request qualified for the PC
//   JmpNe     jne request qualified for the PC
//   Zero      registered zero flag
//   DestAddr  contents of BR[BrSel], zero when BrSel is 3
//   LoadBusy  a low part is staged and waiting for its high part
//   BrErr     one-cycle pulse after any illegal event
module branch_ctrl #(
  parameter int L = 10
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [1:0]   BrSel,
  input  logic         WrLo,
  input  logic         WrHi,
  input  logic [7:0]   WrData,
  input  logic         ZeroIn,
  input  logic         FlagWe,
  input  logic         JeReq,
  input  logic         JneReq,
  output logic         JmpEq,
  output logic         JmpNe,
  output logic         Zero,
  output logic [L-1:0] DestAddr,
  output logic         LoadBusy,
  output logic         BrErr
);

  typedef enum logic {
    IDLE,
    LO_HELD
  } load_state_t;

  load_state_t state;
  load_state_t state_next;

  logic [L-1:0] br0;
  logic [L-1:0] br1;
  logic [L-1:0] br2;
  logic [7:0]   st_lo;
  logic [1:0]   st_sel;
  logic         z;
  logic         br_err;

  logic         sel_valid;
  logic         write_bad;
  logic         req_bad;
  logic         capture;
  logic         commit;
  logic         seq_err;
  logic         illegal;
  logic [L-1:0] commit_value;

  // Malformed writes (both strobes, or a write to select 3) never touch
  // state, so they are filtered out before the load FSM sees them.
  assign sel_valid = (BrSel != 2'd3);
  assign write_bad = (WrLo & WrHi) | ((WrLo | WrHi) & ~sel_valid);
  assign req_bad   = (JeReq & JneReq) | ((JeReq | JneReq) & ~sel_valid);

  // Full target assembled from the new high part and the staged low part.
  assign commit_value = {WrData[L-9:0], st_lo};

  // Load FSM next-state logic. A high write is only meaningful while a
  // low part for the same register is staged; every other high write is
  // a sequencing error. A mismatched high write abandons the staged value
  // so a target can never end up half-updated.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    commit     = 1'b0;
    seq_err    = 1'b0;
    if (!write_bad) begin
      unique case (state)
        IDLE: begin
          if (WrLo) begin
            capture    = 1'b1;
            state_next = LO_HELD;
          end else if (WrHi) begin
            seq_err = 1'b1;
          end
        end
        LO_HELD: begin
          if (WrLo) begin
            capture = 1'b1;
          end else if (WrHi) begin
            state_next = IDLE;
            if (BrSel == st_sel) begin
              commit = 1'b1;
            end else begin
              seq_err = 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Several illegal events in one cycle collapse into a single pulse.
  assign illegal = write_bad | req_bad | seq_err;

  // State register, staging registers, branch targets, flag and error pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      br0    <= '0;
      br1    <= '0;
      br2    <= '0;
      st_lo  <= '0;
      st_sel <= '0;
      z      <= 1'b0;
      br_err <= 1'b0;
    end else begin
      state  <= state_next;
      br_err <= illegal;
      if (capture) begin
        st_lo  <= WrData;
        st_sel <= BrSel;
      end
      if (commit) begin
        unique case (st_sel)
          2'd0:    br0 <= commit_value;
          2'd1:    br1 <= commit_value;
          2'd2:    br2 <= commit_value;
          default: ;
        endcase
      end
      if (FlagWe) begin
        z <= ZeroIn;
      end
    end
  end

  // Target lookup reads only committed registers, so a commit and a jump
  // to the same register in one cycle still see the old target.
  always_comb begin
    unique case (BrSel)
      2'd0:    DestAddr = br0;
      2'd1:    DestAddr = br1;
      2'd2:    DestAddr = br2;
      default: DestAddr = '0;
    endcase
  end

  assign JmpEq    = JeReq & ~JneReq & sel_valid;
  assign JmpNe    = JneReq & ~JeReq & sel_valid;
  assign Zero     = z;
  assign LoadBusy = (state == LO_HELD);
  assign BrErr    = br_err;

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl
//   Directed, table-driven bench for branch_ctrl with L = 10. Each record
//   holds the inputs for one cycle and the outputs expected just before
//   the following rising edge. Inputs change on the falling edge.
module tb_branch_ctrl;

  localparam int L = 10;

  logic         Clk;
  logic         Reset;
  logic [1:0]   BrSel;
  logic         WrLo;
  logic         WrHi;
  logic [7:0]   WrData;
  logic         ZeroIn;
  logic         FlagWe;
  logic         JeReq;
  logic         JneReq;
  logic         JmpEq;
  logic         JmpNe;
  logic         Zero;
  logic [L-1:0] DestAddr;
  logic         LoadBusy;
  logic         BrErr;

  int checks;
  int errors;

  typedef struct {
    logic         rst;
    logic [1:0]   sel;
    logic         wlo;
    logic         whi;
    logic [7:0]   wdata;
    logic         zin;
    logic         fwe;
    logic         je;
    logic         jne;
    logic         xjeq;
    logic         xjne;
    logic         xzero;
    logic [L-1:0] xdest;
    logic         xbusy;
    logic         xerr;
  } vec_t;

  vec_t vecs[$];

  branch_ctrl #(.L(L)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .BrSel    (BrSel),
    .WrLo     (WrLo),
    .WrHi     (WrHi),
    .WrData   (WrData),
    .ZeroIn   (ZeroIn),
    .FlagWe   (FlagWe),
    .JeReq    (JeReq),
    .JneReq   (JneReq),
    .JmpEq    (JmpEq),
    .JmpNe    (JmpNe),
    .Zero     (Zero),
    .DestAddr (DestAddr),
    .LoadBusy (LoadBusy),
    .BrErr    (BrErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic vec_t mk(
    input logic rst, input logic [1:0] sel, input logic wlo, input logic whi,
    input logic [7:0] wdata, input logic zin, input logic fwe,
    input logic je, input logic jne,
    input logic xjeq, input logic xjne, input logic xzero,
    input logic [L-1:0] xdest, input logic xbusy, input logic xerr);
    vec_t v;
    v.rst = rst;   v.sel = sel;   v.wlo = wlo;     v.whi = whi;
    v.wdata = wdata; v.zin = zin; v.fwe = fwe;     v.je = je;
    v.jne = jne;   v.xjeq = xjeq; v.xjne = xjne;   v.xzero = xzero;
    v.xdest = xdest; v.xbusy = xbusy; v.xerr = xerr;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    Reset  = v.rst;
    BrSel  = v.sel;
    WrLo   = v.wlo;
    WrHi   = v.whi;
    WrData = v.wdata;
    ZeroIn = v.zin;
    FlagWe = v.fwe;
    JeReq  = v.je;
    JneReq = v.jne;
  endtask

  task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    #1;
    cmp({tag, ".JmpEq"},    16'(JmpEq),    16'(v.xjeq));
    cmp({tag, ".JmpNe"},    16'(JmpNe),    16'(v.xjne));
    cmp({tag, ".Zero"},     16'(Zero),     16'(v.xzero));
    cmp({tag, ".DestAddr"}, 16'(DestAddr), 16'(v.xdest));
    cmp({tag, ".LoadBusy"}, 16'(LoadBusy), 16'(v.xbusy));
    cmp({tag, ".BrErr"},    16'(BrErr),    16'(v.xerr));
  endtask

  initial begin
    vec_t rv;
    vec_t hs[$];
    checks = 0;
    errors = 0;

    // Load BR1 = 0x2A5 and watch LoadBusy for one cycle.
    vecs.push_back(mk(0,1,1,0,8'hA5,0,0,0,0, 0,0,0,10'h000,0,0));
    vecs.push_back(mk(0,1,0,1,8'h02,0,0,0,0, 0,0,0,10'h000,1,0));
    vecs.push_back(mk(0,1,0,0,8'h00,0,0,0,0, 0,0,0,10'h2A5,0,0));
    // Compare sets the flag, then je and jne use it.
    vecs.push_back(mk(0,1,0,0,8'h00,1,1,0,0, 0,0,0,10'h2A5,0,0));
    vecs.push_back(mk(0,1,0,0,8'h00,0,0,1,0, 1,0,1,10'h2A5,0,0));
    vecs.push_back(mk(0,1,0,0,8'h00,0,0,0,1, 0,1,1,10'h2A5,0,0));
    // Compare clearing the flag in the same cycle as je sees the old flag.
    vecs.push_back(mk(0,1,0,0,8'h00,0,1,1,0, 1,0,1,10'h2A5,0,0));
    vecs.push_back(mk(0,1,0,0,8'h00,0,0,0,0, 0,0,0,10'h2A5,0,0));
    // Low to sel 0, high to sel 2: error, nothing committed.
    vecs.push_back(mk(0,0,1,0,8'h33,0,0,0,0, 0,0,0,10'h000,0,0));
    vecs.push_back(mk(0,2,0,1,8'h03,0,0,0,0, 0,0,0,10'h000,1,0));
    vecs.push_back(mk(0,0,0,0,8'h00,0,0,0,0, 0,0,0,10'h000,0,1));
    vecs.push_back(mk(0,2,0,0,8'h00,0,0,0,0, 0,0,0,10'h000,0,0));
    // Lone high write in IDLE.
    vecs.push_back(mk(0,0,0,1,8'h01,0,0,0,0, 0,0,0,10'h000,0,0));
    vecs.push_back(mk(0,0,0,0,8'h00,0,0,0,0, 0,0,0,10'h000,0,1));
    // Both write strobes together.
    vecs.push_back(mk(0,1,1,1,8'hFF,0,0,0,0, 0,0,0,10'h2A5,0,0));
    vecs.push_back(mk(0,1,0,0,8'h00,0,0,0,0, 0,0,0,10'h2A5,0,1));
    // je with select 3.
    vecs.push_back(mk(0,3,0,0,8'h00,0,0,1,0, 0,0,0,10'h000,0,0));
    vecs.push_back(mk(0,1,0,0,8'h00,0,0,0,0, 0,0,0,10'h2A5,0,1));
    // je and jne together, then confirm the pulse lasts one cycle.
    vecs.push_back(mk(0,1,0,0,8'h00,0,0,1,1, 0,0,0,10'h2A5,0,0));
    vecs.push_back(mk(0,1,0,0,8'h00,0,0,0,0, 0,0,0,10'h2A5,0,1));
    vecs.push_back(mk(0,1,0,0,8'h00,0,0,0,0, 0,0,0,10'h2A5,0,0));
    // Two illegal events in one cycle give one pulse.
    vecs.push_back(mk(0,3,0,1,8'h01,0,0,1,0, 0,0,0,10'h000,0,0));
    vecs.push_back(mk(0,3,0,0,8'h00,0,0,0,0, 0,0,0,10'h000,0,1));
    vecs.push_back(mk(0,3,0,0,8'h00,0,0,0,0, 0,0,0,10'h000,0,0));
    // Restart: low to sel 0 replaced by low to sel 2, then commit BR2.
    vecs.push_back(mk(0,0,1,0,8'h11,0,0,0,0, 0,0,0,10'h000,0,0));
    vecs.push_back(mk(0,2,1,0,8'h22,0,0,0,0, 0,0,0,10'h000,1,0));
    vecs.push_back(mk(0,2,0,1,8'h01,0,0,0,0, 0,0,0,10'h000,1,0));
    vecs.push_back(mk(0,2,0,0,8'h00,0,0,0,0, 0,0,0,10'h122,0,0));
    // Commit and jump to the same register in one cycle use the old target.
    vecs.push_back(mk(0,2,1,0,8'h44,0,0,0,0, 0,0,0,10'h122,0,0));
    vecs.push_back(mk(0,2,0,1,8'h03,0,0,1,0, 1,0,0,10'h122,1,0));
    vecs.push_back(mk(0,2,0,0,8'h00,0,0,0,0, 0,0,0,10'h344,0,0));
    vecs.push_back(mk(0,0,0,0,8'h00,0,0,0,0, 0,0,0,10'h000,0,0));

    // Reset values.
    rv = mk(1,0,0,0,8'h00,0,0,0,0, 0,0,0,10'h000,0,0);
    applyStimulus(rv);
    @(posedge Clk);
    @(negedge Clk);
    checkOutput(rv, "reset");

    foreach (vecs[i]) begin
      @(negedge Clk);
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], $sformatf("v%0d", i));
    end

    // Reset while a low part is staged; the later high write is illegal
    // and every register, including the flag, is back at zero.
    hs.push_back(mk(0,2,1,0,8'h11,1,1,0,0, 0,0,0,10'h344,0,0));
    hs.push_back(mk(1,2,0,0,8'h00,0,0,0,0, 0,0,1,10'h344,1,0));
    hs.push_back(mk(0,2,0,1,8'h01,0,0,0,0, 0,0,0,10'h000,0,0));
    hs.push_back(mk(0,2,0,0,8'h00,0,0,0,0, 0,0,0,10'h000,0,1));
    hs.push_back(mk(0,1,0,0,8'h00,0,0,0,0, 0,0,0,10'h000,0,0));
    foreach (hs[i]) begin
      @(negedge Clk);
      applyStimulus(hs[i]);
      checkOutput(hs[i], $sformatf("rst%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch-control unit that drives the program counter's jump inputs: `JmpEq`, `JmpNe`, `Zero` and `DestAddr`. It holds the three dedicated branch-target registers. It loads each register from the narrow data path by an atomic two-step (low, then high) write, and it keeps the ALU zero flag between a compare and the branch that consumes it. It sits between the decoder/ALU and the PC; all its jump outputs are valid in the same cycle as the branch instruction.

## Interface
- `L`, 10: width of PC and branch targets; legal range 9..16.
- `Clk`  in  1  clock; all state changes on posedge.
- `Reset`  in  1  synchronous, active-high; clears all state.
- `BrSel`  in  2  branch register select: 0..2 valid, 3 illegal.
- `WrLo`  in  1  write `WrData[7:0]` as the low part of target `BrSel`.
- `WrHi`  in  1  write `WrData[L-9:0]` as the high part of target `BrSel`, and commit.
- `WrData`  in  8  write data; bits above `L-9` are ignored on `WrHi`.
- `ZeroIn`  in  1  ALU zero result.
- `FlagWe`  in  1  compare instruction: latch `ZeroIn` into the flag.
- `JeReq`  in  1  decoder has a `je` instruction.
- `JneReq`  in  1  decoder has a `jne` instruction.
- `JmpEq`  out  1  to PC; combinational.
- `JmpNe`  out  1  to PC; combinational.
- `Zero`  out  1  to PC; registered flag.
- `DestAddr`  out  L  to PC; equals `BR[BrSel]`, combinational, 0 when `BrSel`==3.
- `LoadBusy`  out  1  registered; 1 while a low part is staged.
- `BrErr`  out  1  registered one-cycle pulse on an illegal event.

## Operation
- State: `BR0`..`BR2` (L bits each), staging `StLo[7:0]`, staging select `StSel[1:0]`, load FSM, flag `Z`.
- Reset values: all BR = 0, `StLo` = 0, `StSel` = 0, FSM = `IDLE`, `Z` = 0, `LoadBusy` = 0, `BrErr` = 0.
- Load FSM states are `IDLE` and `LO_HELD`:
  - `IDLE` + `WrLo` with valid `BrSel`: capture `StLo`/`StSel`, go to `LO_HELD`.
  - `IDLE` + `WrHi`: illegal. Ignore the write, stay in `IDLE`.
  - `LO_HELD` + `WrHi` with `BrSel`==`StSel`: `BR[StSel]` <= {`WrData[L-9:0]`, `StLo`}, go to `IDLE`.
  - `LO_HELD` + `WrHi` with `BrSel`!=`StSel`: illegal. Discard the staged value, go to `IDLE`; no BR changes.
  - `LO_HELD` + `WrLo` with valid `BrSel`: restart. Overwrite `StLo`/`StSel`, stay in `LO_HELD`.
  - `WrLo` and `WrHi` asserted together, or a write with `BrSel`==3: illegal. No state change.
- A BR register never holds a half-updated value.
- `LoadBusy` = (FSM == `LO_HELD`).
- Flag: `Z` <= `ZeroIn` on any edge where `FlagWe`=1. Otherwise it holds. `Zero` = `Z`.
- Jump outputs:
  - `JmpEq` = `JeReq` & ~`JneReq` & (`BrSel`!=3).
  - `JmpNe` = `JneReq` & ~`JeReq` & (`BrSel`!=3).
  - Both requests together, or a request with `BrSel`==3: illegal. Both outputs are 0, so the PC increments.
- `BrErr` = 1 on the edge after any illegal event, for exactly one cycle. Multiple illegal events in one cycle give a single pulse.
- Reset during `LO_HELD` discards the staged value; a later `WrHi` is then illegal.

## Timing
- A jump decision uses the values present at the start of the cycle:
  - `DestAddr` reflects BR contents committed on earlier edges.
  - A `WrHi` commit and a jump to the same register in the same cycle use the old target.
- `FlagWe` in cycle n is visible on `Zero` from cycle n+1. `FlagWe` and a jump in the same cycle use the old flag.
- No bypass paths; the minimum compare-to-branch distance is 1 cycle.
- `LoadBusy` and `BrErr` update one edge after the causing input.
- Jump outputs are pure combinational paths from inputs and registers; they have no latency.
- The three BR registers never alias each other.

## Test plan
- Reset, then `WrLo` `0xA5` and `WrHi` `0x02` to sel 1 -> `BR1` = `0x2A5`. With `BrSel`=1, `DestAddr` = `0x2A5`; `LoadBusy` is 1 for exactly one cycle.
- `FlagWe`=1 with `ZeroIn`=1, next cycle `JeReq` sel 1 -> `JmpEq`=1 and `Zero`=1. Same setup with `JneReq` -> `JmpNe`=1 (the PC will not take it).
- `FlagWe`=1/`ZeroIn`=0 and `JeReq` in the same cycle, with the prior flag = 1 -> `Zero` is still 1 that cycle. In the next cycle `Zero`=0.
- `WrLo` sel 0, then `WrHi` sel 2 -> `BrErr` pulses once, `BR0` and `BR2` are unchanged, and the FSM is in `IDLE`.
- Lone `WrHi` in `IDLE`; `WrLo`+`WrHi` together; `BrSel`=3 with `JeReq`; `JeReq`+`JneReq` together -> each produces one `BrErr` pulse, `JmpEq`=`JmpNe`=0, and no register changes.
- `WrLo` `0x11` sel 2, then `Reset`, then `WrHi` `0x01` sel 2 -> `BR2` stays 0, `BrErr` pulses, and all outputs are at reset values after `Reset`.
